// File: rtl/jtaglet_pkg.sv
// jtaglet_pkg: TAP state enumeration and instruction opcode helpers shared by
// the jtaglet_multi block and its TAP controller.
package jtaglet_pkg;

    typedef enum logic [3:0] {
        TAP_TLR,
        TAP_RTI,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SHIFT_DR,
        TAP_EXIT1_DR,
        TAP_PAUSE_DR,
        TAP_EXIT2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SHIFT_IR,
        TAP_EXIT1_IR,
        TAP_PAUSE_IR,
        TAP_EXIT2_IR,
        TAP_UPD_IR
    } tap_state_e;

    // IDCODE opcode: all ones except the LSB
    function automatic logic [7:0] idcode_op(input int unsigned ir_len);
        return 8'((32'd1 << ir_len) - 32'd2);
    endfunction

    // BYPASS opcode: all ones
    function automatic logic [7:0] bypass_op(input int unsigned ir_len);
        return 8'((32'd1 << ir_len) - 32'd1);
    endfunction

    // USERCODE opcode: all ones above a 2'b01 tail
    function automatic logic [7:0] usercode_op(input int unsigned ir_len);
        return 8'((32'd1 << ir_len) - 32'd3);
    endfunction

endpackage

// File: rtl/jtaglet_multi_if.sv
// jtaglet_multi_if: per-channel user data bus between the TAP and user logic.
interface jtaglet_multi_if #(
    parameter int unsigned NUM_USER     = 4,
    parameter int unsigned USERDATA_LEN = 32
);
    logic [NUM_USER*USERDATA_LEN-1:0] user_din;
    logic [NUM_USER*USERDATA_LEN-1:0] user_dout;
    logic [NUM_USER-1:0]              user_upd;
    logic [NUM_USER-1:0]              user_cap;

    modport master (output user_din, input user_dout, input user_upd, input user_cap);
    modport slave  (input user_din, output user_dout, output user_upd, output user_cap);
endinterface

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: 16-state IEEE 1149.1 TAP controller with one-hot state decodes.
module jtag_tap_fsm
    import jtaglet_pkg::*;
(
    input  logic tck,
    input  logic trst,
    input  logic tms,
    output logic tlr_c,
    output logic cap_dr_c,
    output logic shift_dr_c,
    output logic upd_dr_c,
    output logic cap_ir_c,
    output logic shift_ir_c,
    output logic upd_ir_c
);

    tap_state_e state_q, state_d;

    // state register
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) state_q <= TAP_TLR;
        else       state_q <= state_d;
    end

    // next state from tms and state decodes
    always_comb begin
        state_d    = state_q;
        tlr_c      = 1'b0;
        cap_dr_c   = 1'b0;
        shift_dr_c = 1'b0;
        upd_dr_c   = 1'b0;
        cap_ir_c   = 1'b0;
        shift_ir_c = 1'b0;
        upd_ir_c   = 1'b0;
        case (state_q)
            TAP_TLR:      begin tlr_c = 1'b1; state_d = tms ? TAP_TLR : TAP_RTI; end
            TAP_RTI:      state_d = tms ? TAP_SEL_DR   : TAP_RTI;
            TAP_SEL_DR:   state_d = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   begin cap_dr_c = 1'b1; state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR; end
            TAP_SHIFT_DR: begin shift_dr_c = 1'b1; state_d = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR; end
            TAP_EXIT1_DR: state_d = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_d = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: state_d = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   begin upd_dr_c = 1'b1; state_d = tms ? TAP_SEL_DR : TAP_RTI; end
            TAP_SEL_IR:   state_d = tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   begin cap_ir_c = 1'b1; state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR; end
            TAP_SHIFT_IR: begin shift_ir_c = 1'b1; state_d = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR; end
            TAP_EXIT1_IR: state_d = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_d = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: state_d = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   begin upd_ir_c = 1'b1; state_d = tms ? TAP_SEL_DR : TAP_RTI; end
            default:      state_d = TAP_TLR;
        endcase
    end

endmodule

// File: rtl/jtaglet_multi.sv
// jtaglet_multi: JTAG TAP with IDCODE, BYPASS and NUM_USER user data channels.
// Optional feature macro: JTAGLET_MULTI_USERCODE_EN adds a read-only USERCODE DR.
module jtaglet_multi
    import jtaglet_pkg::*;
#(
    parameter int unsigned IR_LEN       = 5,
    parameter int unsigned NUM_USER     = 4,
    parameter int unsigned USERDATA_LEN = 32,
    parameter logic [7:0]  USER_BASE_OP = 8'h08,
    parameter logic [3:0]  ID_PARTVER   = 4'h0,
    parameter logic [15:0] ID_PARTNUM   = 16'h0000,
`ifdef JTAGLET_MULTI_USERCODE_EN
    parameter logic [10:0] ID_MANF      = 11'h000,
    parameter logic [31:0] USERCODE     = 32'h0
`else
    parameter logic [10:0] ID_MANF      = 11'h000
`endif
) (
    input  logic              tck,
    input  logic              trst,
    input  logic              tms,
    input  logic              tdi,
    output logic              tdo,
    output logic              tdo_en,
    jtaglet_multi_if.slave    bus
);

    localparam int unsigned       UW          = USERDATA_LEN;
    localparam logic [IR_LEN-1:0] IDCODE_OP   = IR_LEN'(idcode_op(IR_LEN));
    localparam logic [IR_LEN-1:0] USERCODE_OP = IR_LEN'(usercode_op(IR_LEN));
    localparam logic [31:0]       IDCODE_VAL  = {ID_PARTVER, ID_PARTNUM, ID_MANF, 1'b1};

    // user opcodes must stay clear of USERCODE/IDCODE/BYPASS
    if (int'(USER_BASE_OP) + int'(NUM_USER) - 1 >= int'(USERCODE_OP)) begin : g_op_overlap
        $error("jtaglet_multi: user opcodes overlap the reserved opcode range");
    end

    logic tlr_c, cap_dr_c, shift_dr_c, upd_dr_c, cap_ir_c, shift_ir_c, upd_ir_c;

    jtag_tap_fsm u_tap (
        .tck        (tck),
        .trst       (trst),
        .tms        (tms),
        .tlr_c      (tlr_c),
        .cap_dr_c   (cap_dr_c),
        .shift_dr_c (shift_dr_c),
        .upd_dr_c   (upd_dr_c),
        .cap_ir_c   (cap_ir_c),
        .shift_ir_c (shift_ir_c),
        .upd_ir_c   (upd_ir_c)
    );

    logic [IR_LEN-1:0]        ir_shift, ir_active;
    logic [31:0]              dr32;
    logic                     bypass_q;
    logic [NUM_USER*UW-1:0]   user_sr, user_dout_q;
    logic [NUM_USER-1:0]      user_upd_q, user_cap_q;
    logic [NUM_USER-1:0]      sel_user;
    logic                     sel_id, sel_uc, sel_byp, dr_lsb;

    // instruction decode; unknown opcodes fall through to BYPASS
    always_comb begin
        sel_user = '0;
        for (int k = 0; k < int'(NUM_USER); k++) begin
            if (ir_active == IR_LEN'(int'(USER_BASE_OP) + k)) sel_user[k] = 1'b1;
        end
        sel_id = (ir_active == IDCODE_OP);
`ifdef JTAGLET_MULTI_USERCODE_EN
        sel_uc = (ir_active == USERCODE_OP);
`else
        sel_uc = 1'b0;
`endif
        sel_byp = !(sel_id || sel_uc || (|sel_user));
    end

    // serial output bit of the selected DR
    always_comb begin
        dr_lsb = bypass_q;
        if (sel_id || sel_uc) dr_lsb = dr32[0];
        for (int k = 0; k < int'(NUM_USER); k++) begin
            if (sel_user[k]) dr_lsb = user_sr[k*UW];
        end
    end

    // IR capture/shift/update; TLR reselects IDCODE
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            ir_shift  <= '0;
            ir_active <= IDCODE_OP;
        end else begin
            if (cap_ir_c)        ir_shift <= IR_LEN'(1);
            else if (shift_ir_c) ir_shift <= {tdi, ir_shift[IR_LEN-1:1]};
            if (tlr_c)           ir_active <= IDCODE_OP;
            else if (upd_ir_c)   ir_active <= ir_shift;
        end
    end

    // DR capture and shift; only the selected register moves
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            dr32     <= '0;
            bypass_q <= 1'b0;
            user_sr  <= '0;
        end else if (cap_dr_c) begin
            if (sel_byp) bypass_q <= 1'b0;
            if (sel_id)  dr32 <= IDCODE_VAL;
`ifdef JTAGLET_MULTI_USERCODE_EN
            if (sel_uc)  dr32 <= USERCODE;
`endif
            for (int k = 0; k < int'(NUM_USER); k++) begin
                if (sel_user[k]) user_sr[k*UW +: UW] <= bus.user_din[k*UW +: UW];
            end
        end else if (shift_dr_c) begin
            if (sel_byp)          bypass_q <= tdi;
            if (sel_id || sel_uc) dr32 <= {tdi, dr32[31:1]};
            for (int k = 0; k < int'(NUM_USER); k++) begin
                if (sel_user[k]) user_sr[k*UW +: UW] <= UW'({tdi, user_sr[k*UW +: UW]} >> 1);
            end
        end
    end

    // user update holding registers and one-cycle strobes; TLR leaves them alone
    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            user_dout_q <= '0;
            user_upd_q  <= '0;
            user_cap_q  <= '0;
        end else begin
            user_cap_q <= cap_dr_c ? sel_user : '0;
            user_upd_q <= upd_dr_c ? sel_user : '0;
            if (upd_dr_c) begin
                for (int k = 0; k < int'(NUM_USER); k++) begin
                    if (sel_user[k]) user_dout_q[k*UW +: UW] <= user_sr[k*UW +: UW];
                end
            end
        end
    end

    // tdo and tdo_en launch on the falling edge
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo_en <= shift_dr_c || shift_ir_c;
            tdo    <= shift_ir_c ? ir_shift[0] : (shift_dr_c ? dr_lsb : 1'b0);
        end
    end

    assign bus.user_dout = user_dout_q;
    assign bus.user_upd  = user_upd_q;
    assign bus.user_cap  = user_cap_q;

endmodule

// File: tb/tb_jtaglet_multi.sv
// tb_jtaglet_multi: directed TAP sequences against a transaction-level model of
// the IR/DR contents, with a per-cycle monitor of tdo_en, strobes and user_dout.
module tb_jtaglet_multi;

    logic        tck = 1'b0;
    logic        trst, tms, tdi;
    logic        tdo, tdo_en;

    jtaglet_multi_if #(.NUM_USER(4), .USERDATA_LEN(32)) bus ();

    jtaglet_multi #(
`ifdef JTAGLET_MULTI_USERCODE_EN
        .IR_LEN(5),
        .USERCODE(32'hCAFE0001)
`else
        .IR_LEN(5)
`endif
    ) dut (
        .tck    (tck),
        .trst   (trst),
        .tms    (tms),
        .tdi    (tdi),
        .tdo    (tdo),
        .tdo_en (tdo_en),
        .bus    (bus)
    );

    always #5 tck = ~tck;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_din  [4];
    logic [31:0] m_dout [4];
    logic [3:0]  m_upd = '0, m_cap = '0;
    logic        m_en  = 1'b0;
    logic [4:0]  m_ir  = 5'h1E;
    logic [3:0]  last_upd, last_cap;
    bit          done  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // capture length/value of the register the instruction selects
    function automatic void dr_model(input logic [4:0] ir, output int len,
                                     output logic [63:0] cap, output int ch);
        ch = -1; len = 1; cap = '0;
        if (ir == 5'h1E) begin
            len = 32; cap = 64'({4'h0, 16'h0000, 11'h000, 1'b1});
        end
`ifdef JTAGLET_MULTI_USERCODE_EN
        else if (ir == 5'h1D) begin
            len = 32; cap = 64'h0000_0000_CAFE_0001;
        end
`endif
        else if (ir >= 5'h08 && ir <= 5'h0B) begin
            ch = int'(ir) - 8; len = 32; cap = 64'(m_din[ch]);
        end
    endfunction

    // one tck cycle: sample tdo, apply tms/tdi, set expectations for the next cycle
    task automatic step(input logic t_ms, input logic t_di, input logic en, output logic t_do);
        t_do = tdo;
        tms  = t_ms;
        tdi  = t_di;
        @(posedge tck);
        @(negedge tck);
        #1;
        m_en  = en;
        m_upd = '0;
        m_cap = '0;
    endtask

    // RTI -> load IR -> RTI, returning the bits shifted out
    task automatic shift_ir(input logic [4:0] val, output logic [4:0] rd);
        logic b;
        step(1'b1, 1'b0, 1'b0, b);
        step(1'b1, 1'b0, 1'b0, b);
        step(1'b0, 1'b0, 1'b0, b);
        step(1'b0, 1'b0, 1'b1, b);
        for (int i = 0; i < 5; i++) begin
            step(i == 4, val[i], i != 4, b);
            rd[i] = b;
        end
        step(1'b1, 1'b0, 1'b0, b);
        step(1'b0, 1'b0, 1'b0, b);
        m_ir = val;
        check("ir_capture_readback", 64'(rd), 64'(5'b00001));
    endtask

    // RTI -> shift n bits (optional pause) -> Update-DR -> RTI -> idle
    task automatic shift_dr(input logic [63:0] data, input int n, input int pause_after,
                            output logic [63:0] rd);
        int          len, ch;
        logic [63:0] cap, exp_rd;
        logic        q[$];
        logic        b, last, pz;
        dr_model(m_ir, len, cap, ch);
        for (int i = 0; i < len; i++) q.push_back(cap[i]);
        rd = '0; exp_rd = '0;
        step(1'b1, 1'b0, 1'b0, b);
        step(1'b0, 1'b0, 1'b0, b);
        step(1'b0, 1'b0, 1'b1, b);
        if (ch >= 0) m_cap = 4'(1 << ch);
        last_cap = bus.user_cap;
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            pz   = (pause_after > 0) && (i == pause_after - 1) && !last;
            step(last || pz, data[i], !(last || pz), b);
            rd[i]     = b;
            exp_rd[i] = q.pop_front();
            q.push_back(data[i]);
            if (pz) begin
                step(1'b0, 1'b0, 1'b0, b);
                step(1'b0, 1'b0, 1'b0, b);
                step(1'b1, 1'b0, 1'b0, b);
                step(1'b0, 1'b0, 1'b1, b);
            end
        end
        step(1'b1, 1'b0, 1'b0, b);
        step(1'b0, 1'b0, 1'b0, b);
        if (ch >= 0) begin
            m_upd = 4'(1 << ch);
            for (int j = 0; j < 32; j++) m_dout[ch][j] = q[j];
        end
        last_upd = bus.user_upd;
        step(1'b0, 1'b0, 1'b0, b);
        check("dr_tdo_stream", rd, exp_rd);
    endtask

    // per-cycle monitor of enable, strobes and holding registers
    initial begin
        while (!done) begin
            @(negedge tck);
            #3;
            check("tdo_en", 64'(tdo_en), 64'(m_en));
            if (!m_en) check("tdo_idle", 64'(tdo), 64'd0);
            check("user_upd", 64'(bus.user_upd), 64'(m_upd));
            check("user_cap", 64'(bus.user_cap), 64'(m_cap));
            for (int k = 0; k < 4; k++)
                check($sformatf("user_dout%0d", k), 64'(bus.user_dout[k*32 +: 32]), 64'(m_dout[k]));
        end
    end

    initial begin
        logic [4:0]  ird;
        logic [63:0] rd;
        logic        b;
        for (int k = 0; k < 4; k++) m_dout[k] = '0;
        m_din[0] = 32'h0000_C0DE;
        m_din[1] = 32'h1111_1111;
        m_din[2] = 32'h2222_2222;
        m_din[3] = 32'h1234_5678;
        bus.user_din = {m_din[3], m_din[2], m_din[1], m_din[0]};
        trst = 1'b0; tms = 1'b1; tdi = 1'b0;
        repeat (2) @(negedge tck);
        #1;
        trst = 1'b1;
        check("rst_tdo", 64'(tdo), 64'd0);
        check("rst_tdo_en", 64'(tdo_en), 64'd0);
        check("rst_user_dout", 64'(|bus.user_dout), 64'd0);
        check("rst_strobes", 64'({bus.user_upd, bus.user_cap}), 64'd0);

        // IDCODE after reset
        step(1'b0, 1'b0, 1'b0, b);
        shift_dr(64'd0, 32, 0, rd);
        check("idcode_value", rd, 64'h0000_0001);

        // write channel 1
        shift_ir(5'h09, ird);
        check("ir_first_bits", 64'(ird[1:0]), 64'(2'b01));
        shift_dr(64'hDEAD_BEEF, 32, 0, rd);
        check("ch1_capture", rd, 64'h1111_1111);
        check("ch1_dout", 64'(bus.user_dout[32 +: 32]), 64'hDEAD_BEEF);
        check("ch1_upd_strobe", 64'(last_upd), 64'(4'b0010));

        // read channel 3 (last channel)
        shift_ir(5'h0B, ird);
        shift_dr(64'h0BAD_F00D, 32, 0, rd);
        check("ch3_capture", rd, 64'h1234_5678);
        check("ch3_cap_strobe", 64'(last_cap), 64'(4'b1000));
        check("ch3_dout", 64'(bus.user_dout[96 +: 32]), 64'h0BAD_F00D);

        // channel 0 with a pause in the middle of the shift
        shift_ir(5'h08, ird);
        shift_dr(64'hA5A5_0F0F, 32, 13, rd);
        check("ch0_pause_capture", rd, 64'h0000_C0DE);
        check("ch0_pause_dout", 64'(bus.user_dout[0 +: 32]), 64'hA5A5_0F0F);

        // BYPASS: one-bit delay
        shift_ir(5'h1F, ird);
        shift_dr(64'hA5, 8, 0, rd);
        check("bypass_a5", rd, 64'h4A);

        // first opcode past the user range falls back to BYPASS
        shift_ir(5'h0C, ird);
        shift_dr(64'h3C, 8, 0, rd);
        check("bypass_0c", rd, 64'h78);

        // USERCODE opcode
        shift_ir(5'h1D, ird);
`ifdef JTAGLET_MULTI_USERCODE_EN
        shift_dr(64'd0, 32, 0, rd);
        check("usercode_value", rd, 64'hCAFE_0001);
`else
        shift_dr(64'hA5, 8, 0, rd);
        check("usercode_bypass", rd, 64'h4A);
`endif

        // five tms=1 from mid Shift-DR (BYPASS selected) -> TLR
        shift_ir(5'h1F, ird);
        step(1'b1, 1'b0, 1'b0, b);
        step(1'b0, 1'b0, 1'b0, b);
        step(1'b0, 1'b0, 1'b1, b);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, b);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, b);
        m_ir = 5'h1E;
        check("tlr_keeps_dout", 64'(bus.user_dout[32 +: 32]), 64'hDEAD_BEEF);
        step(1'b0, 1'b0, 1'b0, b);
        shift_dr(64'd0, 32, 0, rd);
        check("tlr_selects_idcode", rd, 64'h0000_0001);

        // trst in the middle of a channel 1 shift
        shift_ir(5'h09, ird);
        step(1'b1, 1'b0, 1'b0, b);
        step(1'b0, 1'b0, 1'b0, b);
        step(1'b0, 1'b0, 1'b1, b);
        m_cap = 4'b0010;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, b);
        trst = 1'b0; tms = 1'b1;
        for (int k = 0; k < 4; k++) m_dout[k] = '0;
        m_en = 1'b0; m_upd = '0; m_cap = '0; m_ir = 5'h1E;
        @(posedge tck);
        @(negedge tck);
        #1;
        trst = 1'b1;
        check("trst_dout_cleared", 64'(|bus.user_dout), 64'd0);
        check("trst_tdo_en", 64'(tdo_en), 64'd0);
        step(1'b1, 1'b0, 1'b0, b);
        step(1'b0, 1'b0, 1'b0, b);
        shift_dr(64'd0, 32, 0, rd);
        check("trst_idcode", rd, 64'h0000_0001);

        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
